// File: rtl/cla_nibble_sequencer.sv
// Two-requester adder: one 4-bit carry-lookahead slice is reused over NIBBLES
// cycles, with round-robin arbitration and a valid/ready result channel.
//
// state | meaning
// IDLE  | waiting for an operand handshake; ready outputs follow round-robin
// ADD   | one nibble per edge through the CLA slice, LSB nibble first
// DONE  | result presented, held until res_valid & res_ready
module cla_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid0,
  input  logic [4*NIBBLES-1:0] in_a0,
  input  logic [4*NIBBLES-1:0] in_b0,
  input  logic                 in_cin0,
  output logic                 in_ready0,
  input  logic                 in_valid1,
  input  logic [4*NIBBLES-1:0] in_a1,
  input  logic [4*NIBBLES-1:0] in_b1,
  input  logic                 in_cin1,
  output logic                 in_ready1,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout,
  output logic                 res_ovf,
  output logic                 res_id,
  output logic                 busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_q, b_q;
  logic          carry;
  logic [IW-1:0] idx;
  logic          last_id;

  logic [3:0] sa, sb, g, p, s;
  logic [4:0] c;
  logic       hs0, hs1;

  // last_id==1 means requester 0 has priority on the next contention
  assign in_ready0 = ~rst & (state == IDLE) & in_valid0 & (~in_valid1 | last_id);
  assign in_ready1 = ~rst & (state == IDLE) & in_valid1 & (~in_valid0 | ~last_id);
  assign hs0 = in_valid0 & in_ready0;
  assign hs1 = in_valid1 & in_ready1;

  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        sa = a_q[4*i +: 4];
        sb = b_q[4*i +: 4];
      end
    end
  end

  // Carry-lookahead slice: every carry is a flat sum of products off carry
  assign g    = sa & sb;
  assign p    = sa ^ sb;
  assign c[0] = carry;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s    = p ^ c[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      last_id   <= 1'b1;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
      res_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs0 || hs1) begin
            a_q     <= hs1 ? in_a1 : in_a0;
            b_q     <= hs1 ? in_b1 : in_b0;
            carry   <= hs1 ? in_cin1 : in_cin0;
            res_id  <= hs1;
            last_id <= hs1;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= ADD;
          end
        end
        ADD: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) res_sum[4*i +: 4] <= s;
          end
          carry <= c[4];
          if (idx == LAST_IDX) begin
            res_cout  <= c[4];
            res_ovf   <= c[3] ^ c[4];
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed bench for cla_nibble_sequencer (NIBBLES=4): vector table plus
// hand-written arbitration, back-pressure and mid-operation reset sequences.
module tb_cla_nibble_sequencer;
  logic        clk, rst;
  logic        in_valid0, in_cin0, in_ready0;
  logic [15:0] in_a0, in_b0;
  logic        in_valid1, in_cin1, in_ready1;
  logic [15:0] in_a1, in_b1;
  logic        res_valid, res_ready, res_cout, res_ovf, res_id, busy;
  logic [15:0] res_sum;

  int tests = 0;
  int fails = 0;

  cla_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid0(in_valid0), .in_a0(in_a0), .in_b0(in_b0), .in_cin0(in_cin0), .in_ready0(in_ready0),
    .in_valid1(in_valid1), .in_a1(in_a1), .in_b1(in_b1), .in_cin1(in_cin1), .in_ready1(in_ready1),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_ovf(res_ovf), .res_id(res_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one operation on channel id, then wait for the result and check it.
  task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] esum, input logic ecout,
                       input logic eovf, input bit consume);
    bit got;
    int lat;
    got = 0;
    @(negedge clk);
    if (id) begin in_valid1 = 1; in_a1 = a; in_b1 = b; in_cin1 = cin; end
    else    begin in_valid0 = 1; in_a0 = a; in_b0 = b; in_cin0 = cin; end
    for (int k = 0; k < 20; k++) begin
      #1;
      if (id ? in_ready1 : in_ready0) begin got = 1; break; end
      @(negedge clk);
    end
    chk("handshake_ready", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    // scramble operands after the handshake; they must not affect the result
    if (id) begin in_valid1 = 0; in_a1 = ~a; in_b1 = ~b; in_cin1 = ~cin; end
    else    begin in_valid0 = 0; in_a0 = ~a; in_b0 = ~b; in_cin0 = ~cin; end
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("res_sum", 32'(res_sum), 32'(esum));
    chk("res_cout", 32'(res_cout), 32'(ecout));
    chk("res_ovf", 32'(res_ovf), 32'(eovf));
    chk("res_id", 32'(res_id), 32'(id));
    if (consume) begin
      @(negedge clk);
      res_ready = 1;
      @(posedge clk);
      #1;
      res_ready = 0;
      chk("idle_after_consume", 32'({busy, res_valid}), 32'd0);
    end
  endtask

  initial begin
    int ids[4];
    logic [15:0] sums[4];
    int when[4];
    int nres;
    int busy_viol;

    vecs[0] = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};

    rst = 1; res_ready = 0;
    in_valid0 = 1; in_a0 = 16'h1111; in_b0 = 16'h2222; in_cin0 = 0;
    in_valid1 = 1; in_a1 = 16'h3333; in_b1 = 16'h4444; in_cin1 = 0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 32'({in_ready0, in_ready1}), 32'd0);
    in_valid0 = 0; in_valid1 = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset_outputs", 32'({res_valid, busy, res_cout, res_ovf, res_id}), 32'd0);
    chk("reset_sum", 32'(res_sum), 32'd0);
    chk("idle_no_valid_ready", 32'({in_ready0, in_ready1}), 32'd0);

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b1);

    // Continuous contention from reset: grants alternate starting with requester 0
    @(negedge clk);
    rst = 1;
    in_valid0 = 1; in_a0 = 16'h0001; in_b0 = 16'h0002; in_cin0 = 0;
    in_valid1 = 1; in_a1 = 16'h0010; in_b1 = 16'h0020; in_cin1 = 0;
    res_ready = 1;
    @(negedge clk);
    rst = 0;
    nres = 0;
    busy_viol = 0;
    for (int cyc = 0; cyc < 60 && nres < 4; cyc++) begin
      @(negedge clk);
      if (busy && (in_ready0 || in_ready1)) busy_viol++;
      if (res_valid) begin
        ids[nres] = int'(res_id);
        sums[nres] = res_sum;
        when[nres] = cyc;
        nres++;
      end
    end
    in_valid0 = 0; in_valid1 = 0;
    chk("rr_count", 32'(nres), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_id", 32'(ids[i]), 32'(i % 2));
      chk("rr_sum", 32'(sums[i]), (i % 2) ? 32'h30 : 32'h3);
    end
    for (int i = 1; i < 4; i++) chk("rr_interval", 32'(when[i] - when[i-1]), 32'd6);
    chk("no_ready_while_busy", 32'(busy_viol), 32'd0);
    @(negedge clk);
    res_ready = 0;
    repeat (2) @(negedge clk);

    // Back-pressure: result held for 10 cycles with both requesters waiting
    do_op(1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    in_valid0 = 1; in_valid1 = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_valid_sum", 32'({res_valid, res_sum}), 32'h1_2345);
      chk("hold_flags_ready", 32'({res_cout, res_ovf, res_id, in_ready0, in_ready1}), 32'd0);
    end
    res_ready = 1;
    @(posedge clk);
    #1;
    res_ready = 0;
    chk("release_idle", 32'({busy, res_valid}), 32'd0);
    chk("release_rr_ready", 32'({in_ready0, in_ready1}), 32'b01);
    in_valid0 = 0; in_valid1 = 0;

    // Reset while idx==2 discards the operation and leaves no stale carry
    @(negedge clk);
    in_valid0 = 1; in_a0 = 16'hFFFF; in_b0 = 16'h0001; in_cin0 = 1;
    @(posedge clk);
    #1;
    in_valid0 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("midreset_state", 32'({res_valid, busy}), 32'd0);
    chk("midreset_sum", 32'(res_sum), 32'd0);
    @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    chk("midreset_no_result", 32'(res_valid), 32'd0);
    do_op(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cla_nibble_sequencer.md
CLA_NIBBLE_SEQUENCER -- requirements
Module: cla_nibble_sequencer

Interface
REQ-001 SHALL have parameter: NIBBLES, default 4, operand width in 4-bit slices (legal 1..8); W = 4*NIBBLES.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: in_valid0  input  1; in_a0  input  W; in_b0  input  W; in_cin0  input  1; in_ready0  output  1. These form the requester-0 operand channel.
REQ-005 SHALL have ports: in_valid1  input  1; in_a1  input  W; in_b1  input  W; in_cin1  input  1; in_ready1  output  1. These form the requester-1 operand channel.
REQ-006 SHALL have ports: res_valid  output  1; res_ready  input  1; res_sum  output  W; res_cout  output  1; res_ovf  output  1 (signed overflow); res_id  output  1 (requester served).
REQ-007 SHALL have port: busy  output  1, high whenever state is not IDLE.

Function
REQ-008 SHALL contain exactly one 4-bit carry-lookahead slice with carry-in: per-bit generate g=a&b and propagate p=a^b; c[i+1]=g[i]|p[i]&c[i], expanded as lookahead terms; sum=p^c.
REQ-009 SHALL compute W-bit additions by time-multiplexing that slice, least significant nibble first, with a 1-bit carry register chaining nibbles.
REQ-010 SHALL implement FSM states IDLE, ADD, DONE.
REQ-011 IDLE: in_ready0 = in_valid0 & (~in_valid1 | last_id==1); in_ready1 = in_valid1 & (~in_valid0 | last_id==0). The combinational valid-to-ready path is permitted.
REQ-012 A handshake is valid&ready at a rising edge. On handshake, the block SHALL latch a, b, cin and id, set nibble index idx=0, set last_id=id, and go to ADD.
REQ-013 In IDLE with neither valid, the FSM SHALL stay in IDLE and the ready outputs SHALL be 0.
REQ-014 Outside IDLE, in_ready0 and in_ready1 SHALL be 0. At most one handshake SHALL occur per edge.
REQ-015 ADD: each edge SHALL store slice sum into res_sum[4*idx+3:4*idx], load the carry register with the slice carry-out, and increment idx.
REQ-016 ADD: on the edge where idx==NIBBLES-1, the FSM SHALL go to DONE instead of incrementing idx.
REQ-017 res_cout SHALL be the final nibble carry-out. res_ovf SHALL be carry-in XOR carry-out of bit W-1.
REQ-018 Latency SHALL be exactly NIBBLES edges from the handshake edge to res_valid=1. For NIBBLES=4, a handshake at edge E0 gives res_valid high after E4.
REQ-019 DONE: res_valid SHALL be 1. res_sum, res_cout, res_ovf and res_id SHALL hold stable until res_valid&res_ready at an edge, after which the FSM goes to IDLE.
REQ-020 No new handshake SHALL be accepted in the cycle a result is consumed. Minimum issue interval SHALL be NIBBLES+2 edges.
REQ-021 Requester operand inputs SHALL be ignored after the handshake edge, so changing them mid-operation has no effect.
REQ-022 res_sum, res_cout and res_ovf SHALL be registered outputs. Only in_ready0 and in_ready1 may be combinational.
REQ-023 Round-robin SHALL alternate grants under continuous contention. A lone requester SHALL be served back-to-back.

Reset
REQ-024 When rst=1 at an edge, the block SHALL set: state=IDLE, idx=0, carry=0, last_id=1 (requester 0 wins the first contention), res_valid=0, res_sum=0, res_cout=0, res_ovf=0, res_id=0, busy=0.
REQ-025 Reset in ADD or DONE SHALL discard the in-flight operation without producing a result. rst SHALL take priority over any simultaneous handshake.
REQ-026 in_ready0 and in_ready1 SHALL be 0 during any cycle in which rst=1.

Verification
REQ-027 Scenario: req0 a=0x00FF, b=0x0001, cin=0 -> res_sum=0x0100, cout=0, ovf=0, id=0, res_valid 4 edges after handshake.
REQ-028 Scenario: req1 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, id=1. Also 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-029 Scenario: a=0xA5A5, b=0x5A5A, cin=1 -> sum=0x0000, cout=1, ovf=0. This checks full-width carry chaining across all nibbles.
REQ-030 Scenario: both valid continuously from reset with distinct operands -> results appear in order id=0,1,0,1. No handshake while busy=1.
REQ-031 Scenario: res_ready held 0 for 10 cycles in DONE -> res_valid and result fields stay constant, both ready outputs stay 0. Releasing res_ready gives IDLE on the next edge.
REQ-032 Scenario: rst pulsed while idx=2 -> next cycle res_valid=0, busy=0, res_sum=0. The next accepted operation completes correctly with no stale carry.
